// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: sequencer that loads A and B (up to 4x4), checks shapes, then steps the MACs.
// Ports: clk/rst, element strobes in; storage write, operand index, mac and result status out.
module mm_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       col_end,
  input  logic       row_end,
  output logic       busy,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [1:0] wr_row,
  output logic [1:0] wr_col,
  output logic [1:0] rd_i,
  output logic [1:0] rd_k,
  output logic [1:0] rd_j,
  output logic       mac_en,
  output logic       mac_clr,
  output logic       res_valid,
  output logic       change_row,
  output logic [1:0] ep,
  output logic       is_legal
);
  typedef enum logic [2:0] {
    LOAD_A, GAP, LOAD_B, CHECK, REPORT, MAC, EMIT
  } state_t;

  state_t     state, nxt;
  logic [2:0] row_cnt, col_cnt, first_len;
  logic [2:0] len, cols_n, rows_n;
  logic [2:0] cols_a, rows_a, cols_b, rows_b;
  logic       err, err_n, err_a, err_b;
  logic [1:0] ep_q, ri, rk, rj;
  logic       loading, take, ovf, last_col, len_bad;
  logic       legal, k_last, j_last, i_last, done;

  assign loading  = (state == LOAD_A) || (state == LOAD_B);
  assign take     = loading && in_valid;
  // a fifth column or fifth row: flag it and drop the element
  assign ovf      = (col_cnt == 3'd4) || (row_cnt == 3'd4);
  // row_end implies col_end
  assign last_col = col_end || row_end;
  assign len      = col_cnt + 3'd1;
  assign len_bad  = (row_cnt != 3'd0) && (len != first_len);
  assign err_n    = err || (take && ovf) || (take && last_col && len_bad);
  // on the first row first_len is not yet registered
  assign cols_n   = (row_cnt == 3'd0) ? len : first_len;
  assign rows_n   = row_cnt + 3'd1;
  assign legal    = !err_a && !err_b && (cols_a == rows_b);
  assign k_last   = ({1'b0, rk} == cols_a - 3'd1);
  assign j_last   = ({1'b0, rj} == cols_b - 3'd1);
  assign i_last   = ({1'b0, ri} == rows_a - 3'd1);
  assign done     = (state == REPORT) ||
                    ((state == EMIT) && j_last && i_last);

  always_ff @(posedge clk) begin
    if (rst || done) begin
      state     <= LOAD_A;
      row_cnt   <= 3'd0;
      col_cnt   <= 3'd0;
      first_len <= 3'd0;
      err       <= 1'b0;
      cols_a    <= 3'd0;
      rows_a    <= 3'd0;
      cols_b    <= 3'd0;
      rows_b    <= 3'd0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      ri        <= 2'd0;
      rk        <= 2'd0;
      rj        <= 2'd0;
      // ep survives a finished job, only reset clears it
      if (rst) ep_q <= 2'b00;
    end else begin
      state <= nxt;
      if (take) begin
        err <= err_n;
        if (col_cnt != 3'd4) col_cnt <= col_cnt + 3'd1;
        if (last_col) begin
          col_cnt <= 3'd0;
          if (row_cnt == 3'd0) first_len <= len;
          if (row_cnt != 3'd4) row_cnt <= rows_n;
        end
        if (row_end) begin
          row_cnt   <= 3'd0;
          first_len <= 3'd0;
          err       <= 1'b0;
          if (state == LOAD_A) begin
            cols_a <= cols_n;
            rows_a <= rows_n;
            err_a  <= err_n;
          end else begin
            cols_b <= cols_n;
            rows_b <= rows_n;
            err_b  <= err_n;
          end
        end
      end
      if (state == CHECK) ep_q <= {err_b, err_a};
      if (state == MAC) rk <= k_last ? 2'd0 : rk + 2'd1;
      if (state == EMIT) begin
        if (j_last) begin
          rj <= 2'd0;
          ri <= ri + 2'd1;
        end else begin
          rj <= rj + 2'd1;
        end
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      LOAD_A:  if (take && row_end) nxt = GAP;
      GAP:     nxt = LOAD_B;
      LOAD_B:  if (take && row_end) nxt = CHECK;
      CHECK:   nxt = legal ? MAC : REPORT;
      REPORT:  nxt = LOAD_A;
      MAC:     if (k_last) nxt = EMIT;
      EMIT:    nxt = (j_last && i_last) ? LOAD_A : MAC;
      default: nxt = LOAD_A;
    endcase
  end

  // outputs are forced quiet while rst is held
  always_comb begin
    busy       = 1'b0;
    wr_en      = 1'b0;
    wr_sel     = 1'b0;
    wr_row     = 2'd0;
    wr_col     = 2'd0;
    rd_i       = 2'd0;
    rd_k       = 2'd0;
    rd_j       = 2'd0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    res_valid  = 1'b0;
    change_row = 1'b0;
    is_legal   = 1'b0;
    ep         = 2'b00;
    if (!rst) begin
      ep   = ep_q;
      busy = !loading;
      if (take && !ovf) begin
        wr_en  = 1'b1;
        wr_sel = (state == LOAD_B);
        wr_row = row_cnt[1:0];
        wr_col = col_cnt[1:0];
      end
      if (state == MAC) begin
        mac_en  = 1'b1;
        mac_clr = (rk == 2'd0);
        rd_i    = ri;
        rd_k    = rk;
        rd_j    = rj;
      end
      if (state == EMIT) begin
        res_valid  = 1'b1;
        is_legal   = 1'b1;
        change_row = j_last;
        rd_i       = ri;
        rd_j       = rj;
      end
      if (state == REPORT) res_valid = 1'b1;
    end
  end
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: directed scenarios for the matrix multiply sequencer.
// A negedge monitor logs writes, macs and result strobes; tasks compare the logs.
module tb_mm_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       col_end = 1'b0;
  logic       row_end = 1'b0;
  logic       busy, wr_en, wr_sel, mac_en, mac_clr;
  logic       res_valid, change_row, is_legal;
  logic [1:0] wr_row, wr_col, rd_i, rd_k, rd_j, ep;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wa = 0, n_wb = 0, n_busy = 0, n_mac = 0;
  int n_clr_bad = 0, mac_run = 0;
  int busy_at_bend = 0, bend_cyc = 0;
  int         rc[$];
  int         rmac[$];
  bit         rcr[$];
  bit         rlg[$];
  logic [1:0] rep[$];
  logic [3:0] rij[$];
  logic [3:0] wa[$];

  mm_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .col_end(col_end), .row_end(row_end),
    .busy(busy), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col),
    .rd_i(rd_i), .rd_k(rd_k), .rd_j(rd_j),
    .mac_en(mac_en), .mac_clr(mac_clr),
    .res_valid(res_valid), .change_row(change_row),
    .ep(ep), .is_legal(is_legal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (busy) n_busy++;
    if (wr_en && !wr_sel) begin
      n_wa++;
      wa.push_back({wr_row, wr_col});
    end
    if (wr_en && wr_sel) n_wb++;
    if (wr_en && wr_sel && row_end) begin
      bend_cyc = cyc;
      busy_at_bend = n_busy;
    end
    if (mac_en) begin
      n_mac++;
      if (mac_clr != (mac_run == 0)) n_clr_bad++;
      mac_run++;
    end
    if (res_valid) begin
      rc.push_back(cyc - bend_cyc);
      rmac.push_back(mac_run);
      rcr.push_back(change_row);
      rlg.push_back(is_legal);
      rep.push_back(ep);
      rij.push_back({rd_i, rd_j});
      mac_run = 0;
    end
  end

  task automatic clear_log();
    n_wa = 0; n_wb = 0; n_busy = 0; n_mac = 0;
    n_clr_bad = 0; mac_run = 0;
    busy_at_bend = 0; bend_cyc = 0;
    rc.delete(); rmac.delete(); rcr.delete();
    rlg.delete(); rep.delete(); rij.delete(); wa.delete();
  endtask

  task automatic drive(input bit v, input bit ce, input bit re);
    @(negedge clk);
    in_valid = v;
    col_end = ce;
    row_end = re;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_row(input int n, input bit last, input bit gappy);
    for (int e = 0; e < n; e++) begin
      if (gappy && (e % 2 == 1)) drive(1'b0, 1'b1, e == 1);
      drive(1'b1, e == n - 1, last && (e == n - 1));
    end
  endtask

  task automatic send_mat(input int r, input int c, input bit gappy);
    for (int i = 0; i < r; i++) send_row(c, i == r - 1, gappy);
  endtask

  task automatic job(input int ra, input int ca, input int rb,
                     input int cb, input bit gappy);
    send_mat(ra, ca, gappy);
    idle(1);
    send_mat(rb, cb, gappy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, wr_en, mac_en, res_valid, is_legal, ep} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0",
               {busy, wr_en, mac_en, res_valid, is_legal, ep});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, mac_en, ep} !== 5'd0) begin
      errors++;
      $display("FAIL reset_release got %b want 0",
               {busy, res_valid, mac_en, ep});
    end
  endtask

  task automatic test_mult_2x3(input bit gappy);
    clear_log();
    job(2, 3, 3, 2, gappy);
    idle(25);
    checks++;
    if (n_wa !== 6 || n_wb !== 6) begin
      errors++;
      $display("FAIL m23_writes g%0d got %0d/%0d want 6/6", gappy, n_wa, n_wb);
    end
    checks++;
    if (busy_at_bend !== 1) begin
      errors++;
      $display("FAIL m23_gap g%0d got %0d want 1", gappy, busy_at_bend);
    end
    checks++;
    if (wa.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wa[k] !== 4'((k / 3) * 4 + k % 3)) begin
          errors++;
          $display("FAIL m23_waddr%0d got %h want %h", k, wa[k],
                   4'((k / 3) * 4 + k % 3));
        end
      end
    end else begin
      errors++;
      $display("FAIL m23_wa_n got %0d want 6", wa.size());
    end
    checks++;
    if (rc.size() !== 4) begin
      errors++;
      $display("FAIL m23_nres g%0d got %0d want 4", gappy, rc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rc[k] !== 5 + 4 * k || rcr[k] !== (k % 2 == 1) ||
            rlg[k] !== 1'b1 || rep[k] !== 2'b00 || rmac[k] !== 3 ||
            rij[k] !== 4'((k / 2) * 4 + k % 2)) begin
          errors++;
          $display("FAIL m23_res%0d g%0d got t%0d cr%0d lg%0d ep%b m%0d ij%h want t%0d cr%0d lg1 ep00 m3 ij%h",
                   k, gappy, rc[k], rcr[k], rlg[k], rep[k], rmac[k], rij[k],
                   5 + 4 * k, k % 2, 4'((k / 2) * 4 + k % 2));
        end
      end
    end
    checks++;
    if (n_clr_bad !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL m23_tail got clrbad%0d busy%b want 0/0", n_clr_bad, busy);
    end
  endtask

  task automatic test_ragged();
    clear_log();
    send_row(3, 1'b0, 1'b0);
    send_row(2, 1'b1, 1'b0);
    idle(1);
    send_mat(2, 2, 1'b0);
    idle(6);
    checks++;
    if (rc.size() !== 1) begin
      errors++;
      $display("FAIL rag_nres got %0d want 1", rc.size());
    end else begin
      checks++;
      if (rep[0] !== 2'b01 || rlg[0] !== 1'b0 || rc[0] !== 2) begin
        errors++;
        $display("FAIL rag_res got ep%b lg%0d t%0d want ep01 lg0 t2",
                 rep[0], rlg[0], rc[0]);
      end
    end
    checks++;
    if (busy !== 1'b0 || n_mac !== 0) begin
      errors++;
      $display("FAIL rag_tail got busy%b mac%0d want 0/0", busy, n_mac);
    end
  endtask

  task automatic test_shape_mismatch();
    checks++;
    if (ep !== 2'b01) begin
      errors++;
      $display("FAIL ep_hold got %b want 01", ep);
    end
    clear_log();
    job(2, 3, 2, 2, 1'b0);
    idle(6);
    checks++;
    if (rc.size() !== 1) begin
      errors++;
      $display("FAIL shp_nres got %0d want 1", rc.size());
    end else begin
      checks++;
      if (rep[0] !== 2'b00 || rlg[0] !== 1'b0 || rcr[0] !== 1'b0) begin
        errors++;
        $display("FAIL shp_res got ep%b lg%0d cr%0d want ep00 lg0 cr0",
                 rep[0], rlg[0], rcr[0]);
      end
    end
    checks++;
    if (n_mac !== 0) begin
      errors++;
      $display("FAIL shp_mac got %0d want 0", n_mac);
    end
  endtask

  task automatic test_4x4();
    clear_log();
    job(4, 4, 4, 4, 1'b0);
    idle(90);
    checks++;
    if (n_wa !== 16 || n_wb !== 16 || n_mac !== 64 || n_clr_bad !== 0) begin
      errors++;
      $display("FAIL q4_counts got wa%0d wb%0d mac%0d clrbad%0d want 16 16 64 0",
               n_wa, n_wb, n_mac, n_clr_bad);
    end
    checks++;
    if (rc.size() !== 16) begin
      errors++;
      $display("FAIL q4_nres got %0d want 16", rc.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (rc[k] !== 6 + 5 * k || rmac[k] !== 4 || rij[k] !== 4'(k) ||
            rcr[k] !== (k % 4 == 3) || rlg[k] !== 1'b1) begin
          errors++;
          $display("FAIL q4_res%0d got t%0d m%0d ij%h cr%0d lg%0d want t%0d m4 ij%h cr%0d lg1",
                   k, rc[k], rmac[k], rij[k], rcr[k], rlg[k],
                   6 + 5 * k, 4'(k), k % 4 == 3);
        end
      end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    send_row(5, 1'b1, 1'b0);
    idle(1);
    send_mat(1, 1, 1'b0);
    idle(6);
    checks++;
    if (n_wa !== 4) begin
      errors++;
      $display("FAIL ovf_writes got %0d want 4", n_wa);
    end
    checks++;
    if (rc.size() !== 1) begin
      errors++;
      $display("FAIL ovf_nres got %0d want 1", rc.size());
    end else begin
      checks++;
      if (rep[0] !== 2'b01 || rlg[0] !== 1'b0) begin
        errors++;
        $display("FAIL ovf_res got ep%b lg%0d want ep01 lg0", rep[0], rlg[0]);
      end
    end
  endtask

  task automatic test_rst_mid_mac();
    clear_log();
    job(2, 3, 3, 2, 1'b0);
    idle(10);
    checks++;
    if (mac_en !== 1'b1 || rd_i !== 2'd1 || rd_j !== 2'd0 ||
        rc.size() !== 2) begin
      errors++;
      $display("FAIL rmm_pre got mac%b i%0d j%0d n%0d want mac1 i1 j0 n2",
               mac_en, rd_i, rd_j, rc.size());
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mac_en, res_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rmm_during got %b want 000", {busy, mac_en, res_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, mac_en, res_valid, ep} !== 5'd0) begin
      errors++;
      $display("FAIL rmm_after got %b want 0", {busy, mac_en, res_valid, ep});
    end
    idle(8);
    checks++;
    if (rc.size() !== 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmm_quiet got n%0d busy%b want n2 busy0", rc.size(), busy);
    end
    clear_log();
    job(1, 1, 1, 1, 1'b0);
    idle(6);
    checks++;
    if (rc.size() !== 1) begin
      errors++;
      $display("FAIL one_nres got %0d want 1", rc.size());
    end else begin
      checks++;
      if (rcr[0] !== 1'b1 || rlg[0] !== 1'b1 || rmac[0] !== 1 ||
          rc[0] !== 3) begin
        errors++;
        $display("FAIL one_res got cr%0d lg%0d m%0d t%0d want cr1 lg1 m1 t3",
                 rcr[0], rlg[0], rmac[0], rc[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_2x3(1'b0);
    test_mult_2x3(1'b1);
    test_ragged();
    test_shape_mismatch();
    test_4x4();
    test_overflow();
    test_rst_mid_mac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mm_seq_ctrl.md
MM_SEQ_CTRL -- requirements
Module: mm_seq_ctrl

Interface
REQ-001 SHALL expose the following ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  element present on the datapath input this cycle.
- col_end  in  1  qualifies in_valid; last element of the current row.
- row_end  in  1  qualifies in_valid; last element of the current matrix.
- busy  out  1  high = not accepting elements.
- wr_en  out  1  write current element into datapath storage.
- wr_sel  out  1  0 = matrix A, 1 = matrix B.
- wr_row  out  2  storage row index.
- wr_col  out  2  storage column index.
- rd_i  out  2  A row / result row index.
- rd_k  out  2  A column / B row (inner) index.
- rd_j  out  2  B column / result column index.
- mac_en  out  1  accumulate A[rd_i][rd_k]*B[rd_k][rd_j].
- mac_clr  out  1  load the accumulator with the product instead of adding it.
- res_valid  out  1  result or status strobe.
- change_row  out  1  with res_valid: last column of a result row.
- ep  out  2  shape error: bit0 = A malformed, bit1 = B malformed.
- is_legal  out  1  with res_valid: multiplication performed.

REQ-002 SHALL use clock port clk and reset port rst; reset is synchronous and active-high.

Function
REQ-003 SHALL support matrices of 1..4 rows and 1..4 columns.
REQ-004 SHALL implement the FSM states LOAD_A, GAP, LOAD_B, CHECK, REPORT, MAC and EMIT.
REQ-005 LOAD_A / LOAD_B:
- busy = 0.
- Each cycle with in_valid = 1: wr_en = 1, wr_sel = 0 (LOAD_A) or 1 (LOAD_B), wr_row/wr_col = current counters.
- The column counter increments per element.
REQ-006 On an element with col_end = 1:
- Record the row length (column counter + 1) and advance the row counter.
- Reset the column counter.
- For rows after the first, a length differing from the first row's length SHALL set the matrix error flag.
REQ-007 An element with row_end = 1 SHALL be treated as also carrying col_end and SHALL end the matrix:
- LOAD_A -> GAP.
- LOAD_B -> CHECK.
REQ-008 A fifth column or fifth row SHALL set the matrix error flag and suppress wr_en; counters saturate at 4.
REQ-009 col_end and row_end with in_valid = 0 SHALL be ignored.
REQ-010 GAP SHALL last exactly 1 cycle with busy = 1, then enter LOAD_B.
REQ-011 CHECK (1 cycle):
- ep is latched as {errB, errA}.
- legal = (ep == 0) and (colsA == rowsB).
- Next state: MAC if legal, else REPORT.
REQ-012 REPORT (1 cycle):
- res_valid = 1, is_legal = 0, change_row = 0, ep held.
- Then LOAD_A.
REQ-013 MAC:
- Iterates rd_k = 0..colsA-1, one cycle each, with mac_en = 1.
- mac_clr = 1 only when rd_k == 0.
- Ends in EMIT.
REQ-014 EMIT (1 cycle):
- res_valid = 1, is_legal = 1, ep = 00.
- change_row = (rd_j == colsB-1).
- Next state: advance rd_j, wrapping to 0 and incrementing rd_i; return to MAC, or to LOAD_A after (rowsA-1, colsB-1).
REQ-015 Timing:
- Result (i,j) SHALL be strobed the cycle after its last mac_en.
- Each result takes colsA+1 cycles; the first res_valid is colsA+2 cycles after the row_end of B.
REQ-016 busy SHALL be 1 in GAP, CHECK, REPORT, MAC and EMIT.
REQ-017 The cycle after the final EMIT or REPORT, busy SHALL be 0 and all counters, flags and shapes SHALL be cleared for the next A.
REQ-018 Outputs not explicitly driven in a state SHALL be 0, except ep, which holds its last CHECK value until the next CHECK.
REQ-019 Arithmetic overflow detection SHALL reside in the datapath; this block SHALL only sequence it.

Reset
REQ-020 rst = 1 SHALL force LOAD_A on the next edge and clear all counters, shapes and error flags; this applies in any state, including mid-MAC.
REQ-021 While rst = 1 and after its release, all outputs SHALL be 0 (busy = 0, ep = 00) until new input arrives.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- 2x3 A then 3x2 B, dense in_valid:
  - Required: 6 writes to A, 1 busy GAP cycle, 6 writes to B.
  - Required: 4 res_valid strobes at 4-cycle spacing, first one 5 cycles after B's row_end.
  - Required: change_row = 0,1,0,1; is_legal = 1; ep = 00.
- A with row lengths 3,2 (ragged), legal 2x2 B -> a single res_valid with ep = 01 and is_legal = 0, then busy = 0.
- A 2x3, B 2x2 (shapes consistent, 3 != 2) -> a single res_valid with ep = 00 and is_legal = 0, no mac_en.
- 4x4 x 4x4 -> 16 results, each preceded by 4 mac_en cycles with mac_clr on the first; one more element on a row -> ep bit set, no wr_en for it.
- in_valid gaps, including col_end asserted with in_valid = 0, during loading -> shapes unaffected and results identical to the dense run.
- rst pulsed during MAC of result (1,0) -> next cycle state LOAD_A, busy = 0, no res_valid; a following 1x1 x 1x1 job yields one result with change_row = 1.
